instruction_fetch: RTL and testbench

Fetch stage that sits directly upstream of InstructionMemory. It owns the program counter, drives the instruction memory's byte address, and captures the returned word into a registered fetch bundle (instr, pc, pc+8). A valid/ready handshake delivers the bundle to decode. Branch redirects from execute flush the bundle and reload the PC.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/pc_register.sv | 33 +++
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] WORD_BYTES           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] ARM_PC_READ_OFFSET   = 32'd8;

  // Registered fetch bundle handed to decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
  } fetch_bundle_t;

  // Occupancy of the single bundle register; FULL means out_valid is high.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bundle_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter for the fetch stage: reset, word-aligned redirect, and
// sequential increment. All arithmetic wraps modulo 2^32.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] PC_STEP      = WORD_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  // Redirect wins over a sequential advance; otherwise the PC holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else if (i_redirect) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_pc <= i_target & ~32'h3;
    end else if (i_load) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the combinational instruction memory from the PC and
// captures the returned word into a one-entry bundle register with a
// valid/ready handshake toward decode. Execute redirects flush the bundle.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise the perf ports read zero.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] PC_STEP        = WORD_BYTES,
  parameter logic [31:0] PC_READ_OFFSET = ARM_PC_READ_OFFSET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus8,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_redirect_count
);

  bundle_state_e r_state;
  fetch_bundle_t r_bundle;
  logic [31:0]   w_pc;
  logic          w_load;

  // A new word is captured when fetching is enabled, no redirect is pending,
  // and the bundle register is empty or being drained this cycle.
  assign w_load = fetch_en & ~redirect_valid & ((r_state == EMPTY) | out_ready);

  pc_register #(
    .RESET_VECTOR (RESET_VECTOR),
    .PC_STEP      (PC_STEP)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_redirect (redirect_valid),
    .i_target   (redirect_target),
    .o_pc       (w_pc)
  );

  // Memory is combinational, so the PC goes straight out as the fetch address.
  assign imem_addr = w_pc;

  // Bundle EMPTY/FULL tracking: redirect flushes, load fills, bare accept drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_bundle <= '0;
    end else if (redirect_valid) begin
      r_state <= EMPTY;
    end else if (w_load) begin
      r_state           <= FULL;
      r_bundle.instr    <= imem_instruction;
      r_bundle.pc       <= w_pc;
      r_bundle.pc_plus8 <= w_pc + PC_READ_OFFSET;
    end else if ((r_state == FULL) && out_ready) begin
      r_state <= EMPTY;
    end
  end

  assign out_valid    = (r_state == FULL);
  assign out_instr    = r_bundle.instr;
  assign out_pc       = r_bundle.pc;
  assign out_pc_plus8 = r_bundle.pc_plus8;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redirect_cnt;

  // Count bundles accepted by decode and redirects seen from execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (out_valid && out_ready) r_fetch_cnt    <= r_fetch_cnt + 32'd1;
      if (redirect_valid)         r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign perf_fetch_count    = r_fetch_cnt;
  assign perf_redirect_count = r_redirect_cnt;
`else
  assign perf_fetch_count    = 32'h0;
  assign perf_redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A PC-level reference model
// predicts each bundle when stimulus is driven and pushes it to a scoreboard;
// bundles are popped and compared when decode accepts them.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus8;
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_redirect_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]   m_pc;
  logic          m_valid;
  fetch_bundle_t sb_q[$];

  always #5 clk = ~clk;

  // Combinational memory: address-dependent words, 0xE5113004 at address 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE511_3004 ^ {a[15:0], a[15:0]};
  endfunction

  assign imem_instruction = mem_word(imem_addr);

  instruction_fetch #(
    .RESET_VECTOR   (RV),
    .PC_STEP        (32'd4),
    .PC_READ_OFFSET (32'd8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_en            (fetch_en),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .imem_addr           (imem_addr),
    .imem_instruction    (imem_instruction),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_instr           (out_instr),
    .out_pc              (out_pc),
    .out_pc_plus8        (out_pc_plus8),
    .perf_fetch_count    (perf_fetch_count),
    .perf_redirect_count (perf_redirect_count)
  );

  task automatic model_reset();
    m_pc    = RV;
    m_valid = 1'b0;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs, check handshake state against the model,
  // score any accepted bundle, advance the model, then step past the edge.
  task automatic cycle(input logic fe, input logic rv, input logic [31:0] rt, input logic rdy);
    fetch_bundle_t exp_b;
    fetch_en        = fe;
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
    #1;
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
    end
    checks++;
    if (imem_addr !== m_pc) begin
      errors++;
      $display("FAIL imem_addr: got %h expected %h at %0t", imem_addr, m_pc, $time);
    end
    if (m_valid && rdy) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got accept expected none queued at %0t", $time);
      end else begin
        exp_b = sb_q.pop_front();
        checks++;
        if (out_instr !== exp_b.instr) begin
          errors++;
          $display("FAIL out_instr: got %h expected %h at %0t", out_instr, exp_b.instr, $time);
        end
        checks++;
        if (out_pc !== exp_b.pc) begin
          errors++;
          $display("FAIL out_pc: got %h expected %h at %0t", out_pc, exp_b.pc, $time);
        end
        checks++;
        if (out_pc_plus8 !== exp_b.pc_plus8) begin
          errors++;
          $display("FAIL out_pc_plus8: got %h expected %h at %0t", out_pc_plus8, exp_b.pc_plus8, $time);
        end
      end
    end
    if (rv) begin
      sb_q.delete();
      m_valid = 1'b0;
      m_pc    = rt & ~32'h3;
    end else if (fe && (!m_valid || rdy)) begin
      sb_q.push_back('{instr: mem_word(m_pc), pc: m_pc, pc_plus8: m_pc + 32'd8});
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    fetch_en        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    out_ready       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (imem_addr !== RV) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RV); end
    checks++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_plus8 !== 32'h0) begin
      errors++;
      $display("FAIL reset_bundle: got %h/%h/%h expected zeros", out_instr, out_pc, out_pc_plus8);
    end
    checks++;
    if (perf_fetch_count !== 32'h0 || perf_redirect_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_perf: got %h/%h expected zeros", perf_fetch_count, perf_redirect_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_stall();
    test_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (out_pc !== 32'h4 || out_instr !== mem_word(32'h4)) begin
        errors++;
        $display("FAIL stall_hold: got pc %h instr %h expected pc 4 instr %h", out_pc, out_instr, mem_word(32'h4));
      end
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_redirect();
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0013, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL redirect_flush: got valid %b addr %h expected 0 and 00000010", out_valid, imem_addr);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
      errors++;
      $display("FAIL redirect_target: got valid %b pc %h expected 1 and 00000010", out_valid, out_pc);
    end
    // Redirect in the same cycle decode accepts the old bundle.
    cycle(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0202, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      errors++;
      $display("FAIL b2b_last_wins: got valid %b pc %h expected 1 and 00000200", out_valid, out_pc);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_halt();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== RV || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got valid %b addr %h pc %h expected 0/%h/0", out_valid, imem_addr, out_pc, RV);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (out_pc !== 32'hFFFF_FFFC || out_pc_plus8 !== 32'h0000_0004) begin
      errors++;
      $display("FAIL wrap_bundle: got pc %h plus8 %h expected fffffffc and 00000004", out_pc, out_pc_plus8);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (out_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: got pc %h expected 00000000", out_pc);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic fe, rv, rdy;
    for (int i = 0; i < 80; i++) begin
      fe  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(fe, rv, $urandom, rdy);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_fetch;
    logic [31:0] exp_redir;
    test_reset();
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0080, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0090, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    exp_fetch = 32'd10;
    exp_redir = 32'd2;
`else
    exp_fetch = 32'd0;
    exp_redir = 32'd0;
`endif
    checks++;
    if (perf_fetch_count !== exp_fetch) begin
      errors++;
      $display("FAIL perf_fetch: got %0d expected %0d", perf_fetch_count, exp_fetch);
    end
    checks++;
    if (perf_redirect_count !== exp_redir) begin
      errors++;
      $display("FAIL perf_redirect: got %0d expected %0d", perf_redirect_count, exp_redir);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
